// File: rtl/bsg_arb_rr_encode_sched_pkg.sv
// Shared definitions for the round-robin encode schedulers: tag-width rule and FSM states.
// Sibling schedulers import this so their tag widths always match.
package bsg_arb_rr_encode_sched_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } sched_state_e;

    // A single requester still needs a 1-bit tag.
    function automatic int lg_width_f(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bsg_arb_rr_encode_sched_if.sv
// Request/grant bundle between requesters, the scheduler and the downstream consumer.
// The master modport is the scheduler side.
interface bsg_arb_rr_encode_sched_if
    import bsg_arb_rr_encode_sched_pkg::*;
#(
    parameter int width_p    = 8,
    parameter int lg_width_p = lg_width_f(width_p)
);

    logic [width_p-1:0]    reqs_i;
    logic                  v_o;
    logic [width_p-1:0]    grants_one_hot_o;
    logic [lg_width_p-1:0] tag_o;
    logic                  yumi_i;

    modport master (
        input  reqs_i,
        input  yumi_i,
        output v_o,
        output grants_one_hot_o,
        output tag_o
    );

    modport slave (
        output reqs_i,
        output yumi_i,
        input  v_o,
        input  grants_one_hot_o,
        input  tag_o
    );

endinterface

// File: rtl/bsg_arb_rr_encode_sched_encode.sv
// One-hot to binary encoder; the result is 0 for an all-zero input.
module bsg_encode_one_hot
    import bsg_arb_rr_encode_sched_pkg::*;
#(
    parameter int width_p    = 8,
    parameter int lg_width_p = lg_width_f(width_p)
) (
    input  logic [width_p-1:0]    one_hot_i,
    output logic [lg_width_p-1:0] addr_o
);

    always_comb begin
        addr_o = '0;
        for (int unsigned k = 0; k < width_p; k++) begin
            if (one_hot_i[k]) begin
                addr_o = addr_o | lg_width_p'(k);
            end
        end
    end

endmodule

// File: rtl/bsg_arb_rr_encode_sched.sv
// Round-robin scheduler: registers a one-hot grant and its binary tag and holds
// them until the consumer asserts yumi_i.
module bsg_arb_rr_encode_sched
    import bsg_arb_rr_encode_sched_pkg::*;
#(
    parameter int width_p    = 8,
    parameter int lg_width_p = lg_width_f(width_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    bsg_arb_rr_encode_sched_if.master       sched_if
);

    sched_state_e          state_r;
    logic [width_p-1:0]    last_oh_r;
    logic [width_p-1:0]    grant_r;
    logic [lg_width_p-1:0] tag_r;

    logic [width_p-1:0]    reqs;
    logic [width_p-1:0]    hi_mask;
    logic [width_p-1:0]    grant_n;
    logic [lg_width_p-1:0] tag_n;
    logic [2*width_p-1:0]  dbl;
    logic [2*width_p-1:0]  dbl_iso;
    logic                  v;
    logic                  window;

    assign reqs   = sched_if.reqs_i;
    assign v      = (state_r == GRANT);
    assign window = !v || sched_if.yumi_i;

    // Lower half holds requests above the last winner, upper half the full set, so
    // the lowest set bit of the doubled vector is the round-robin winner; folding
    // the halves gives the one-hot grant.
    always_comb begin
        hi_mask = ~((last_oh_r << 1) - width_p'(1));
        dbl     = {reqs, reqs & hi_mask};
        dbl_iso = dbl & (~dbl + (2*width_p)'(1));
        grant_n = dbl_iso[width_p-1:0] | dbl_iso[2*width_p-1:width_p];
    end

    bsg_encode_one_hot #(
        .width_p   (width_p),
        .lg_width_p(lg_width_p)
    ) encode (
        .one_hot_i(grant_n),
        .addr_o   (tag_n)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= IDLE;
            grant_r   <= '0;
            tag_r     <= '0;
            last_oh_r <= width_p'(1) << (width_p - 1);
        end else if (window) begin
            if (|reqs) begin
                state_r   <= GRANT;
                grant_r   <= grant_n;
                tag_r     <= tag_n;
                last_oh_r <= grant_n;
            end else begin
                state_r   <= IDLE;
                grant_r   <= '0;
                tag_r     <= '0;
            end
        end
    end

    assign sched_if.v_o              = v;
    assign sched_if.grants_one_hot_o = grant_r;
    assign sched_if.tag_o            = tag_r;

    a_yumi_legal:  assert property (@(posedge clk_i) disable iff (reset_i) sched_if.yumi_i |-> v);
    a_onehot:      assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(grant_r));
    a_v_matches:   assert property (@(posedge clk_i) disable iff (reset_i) v == (|grant_r));
    a_tag_matches: assert property (@(posedge clk_i) disable iff (reset_i)
                                    grant_r == (v ? (width_p'(1) << tag_r) : '0));

endmodule
